i2s_row_sequencer: RTL and testbench
====================================

# i2s_row_sequencer

Source-side controller for the LED module grid's serial stream. Fetches pixel words from frame memory and serializes them, one row at a time, into a 16-bit header followed by one 16-bit word per module, all MSB first. It drives the shared data line and the enable of the gated bit clock that every grid node (one per x,y position) samples. When memory falls behind, it stalls by withholding clock edges.

## Interface
Parameters:
- NUM_ROWS, 8: rows per frame. The row counter wraps from NUM_ROWS-1 to 0. Range 1..64.
- GAP_CYCLES, 2: clock-disabled idle cycles between rows. 0 is legal.

Ports:
- clk  in  1  system clock; one stream bit per enabled cycle
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a frame; ignored while busy
- abort  in  1  synchronous; returns the block to IDLE on the next edge
- num_modules_x  in  4  grid width minus one; latched at start
- num_modules_y  in  4  grid height minus one; latched at start
- word_req  out  1  word request; held high with stable address until accepted
- word_addr  out  14  {row[5:0], idx[7:0]}
- word_data  in  16  pixel word from frame memory
- word_valid  in  1  accepts the request on the cycle where word_req && word_valid
- i2s_data  out  1  serial bit
- i2s_clk_en  out  1  bit-clock enable, fed to the glitch-free clock gate
- busy  out  1  high from start through the last bit of the frame
- frame_done  out  1  one-cycle pulse after the last bit of the frame
- stall_cnt  out  16  present only with I2S_SEQ_STALL_CNT_EN

## Operation
- FSM states: IDLE, HEADER, DATA, GAP.
- IDLE
  - On start, latch nx and ny, set row=0, load the header shifter, go to HEADER.
  - Request word idx 0 at the same time.
- Header format: {nx, ny, 2'b00, row[5:0]}, 16 bits, MSB first.
- Word count per row: W = (nx+1)*(ny+1), range 1..256.
- DATA: W words, idx 0..W-1, MSB first.
- Prefetch buffer
  - One-deep holding register.
  - word_req is asserted whenever the buffer is empty and words remain in the current row.
  - The next request is issued on the cycle after acceptance.
- Word boundaries: at each boundary (the header's last bit or a word's last bit), the shifter loads from the buffer.
- Stall
  - If the buffer is empty at a boundary, the block stalls: i2s_clk_en=0 and i2s_data holds its value.
  - The stall lasts until the word is accepted; shifting resumes on the next cycle.
- End of row
  - After the last data bit: go to GAP for GAP_CYCLES cycles with i2s_clk_en=0.
  - Then increment row, load the header, and go to HEADER.
  - Prefetch of idx 0 for the new row starts when entering GAP.
- End of frame: after the last bit of row NUM_ROWS-1, pulse frame_done, skip GAP, and go to IDLE.
- Abort
  - Next state is IDLE; word_req drops and the buffer is cleared.
  - No frame_done pulse is produced.
  - abort takes priority over start in the same cycle.
- Reset (asynchronous, including mid-frame): every output returns to its reset value immediately.
- Reset values: state=IDLE, word_req=0, word_addr=0, i2s_data=0, i2s_clk_en=0, busy=0, frame_done=0, stall_cnt=0.

## Timing
- start at edge N: busy=1 and i2s_clk_en=1 from N+1; the first header bit appears on i2s_data at N+1.
- One bit per enabled cycle. A stall-free row takes 16+16W enabled cycles plus GAP_CYCLES.
- No-stall condition: if word_valid returns within 15 cycles of word_req rising, the block never stalls.
- Outputs: i2s_data and i2s_clk_en are registered and change only after rising clk.
- Frame end: frame_done is asserted in the cycle after the final bit; busy falls in the same cycle.
- Back-to-back frames: start in the frame_done cycle is accepted.

## Configuration
- I2S_SEQ_STALL_CNT_EN defined:
  - stall_cnt counts the cycles spent in a data-wait stall; GAP cycles are excluded.
  - It saturates at 16'hFFFF and clears at start.
- I2S_SEQ_STALL_CNT_EN undefined: the port and the counter are absent; stall behaviour is otherwise identical.

## Structure
- Shared package i2s_pkg holds:
  - the FSM state enum;
  - HDR_W=16 and WORD_W=16;
  - ROW_W=6 and IDX_W=8;
  - a header-assembly function.
  - i2s_mask uses the same header field constants.
- One sub-module, i2s_word_prefetch: the holding buffer plus request/accept logic. It exposes buf_valid and buf_pop to the FSM.

## Test plan
- nx=ny=3, NUM_ROWS=8, zero-latency memory:
  - row 0 header reads 0x3300, followed by 256 data bits;
  - the row 1 header reads 0x3301;
  - frame_done appears after 8 rows;
  - i2s_clk_en never falls outside GAP.
- Memory latency 40 cycles:
  - stalls of 24 cycles occur at each word boundary;
  - i2s_data holds during each stall;
  - the bitstream is identical to the zero-latency case;
  - with the macro defined, stall_cnt matches the total stall cycles.
- nx=ny=0 and nx=ny=15: W=1 and W=256; word_addr idx ends at 0 and 255 respectively.
- abort during DATA of row 2:
  - IDLE on the next cycle, word_req=0, no frame_done;
  - a following start restarts at row 0.
- rst_n asserted mid-word: all outputs reach their reset values without a clock edge.
- start while busy: ignored. start in the frame_done cycle: accepted, and the header begins the next cycle.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types, field widths and header/word-count helpers for the row sequencer
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_GAP
    } seq_state_t;

    localparam int HDR_W  = 16;
    localparam int WORD_W = 16;
    localparam int ROW_W  = 6;
    localparam int IDX_W  = 8;
    localparam int DIM_W  = 4;
    localparam int CNT_W  = IDX_W + 1;
    localparam int ADDR_W = ROW_W + IDX_W;

    function automatic logic [HDR_W-1:0] make_header(
        input logic [DIM_W-1:0] nx,
        input logic [DIM_W-1:0] ny,
        input logic [ROW_W-1:0] row
    );
        return {nx, ny, 2'b00, row};
    endfunction

    // (nx+1)*(ny+1) needs the full 9 bits: 16*16 = 256.
    function automatic logic [CNT_W-1:0] word_count(
        input logic [DIM_W-1:0] nx,
        input logic [DIM_W-1:0] ny
    );
        logic [CNT_W-1:0] a;
        logic [CNT_W-1:0] b;
        a = CNT_W'(nx) + CNT_W'(1);
        b = CNT_W'(ny) + CNT_W'(1);
        return a * b;
    endfunction

endpackage

// File: rtl/i2s_word_prefetch.sv
// rtl/i2s_word_prefetch.sv - one-deep word holding buffer with frame-memory request/accept handshake
module i2s_word_prefetch
    import i2s_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_row_load,
    input  logic [ROW_W-1:0]  i_row,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              buf_pop,
    output logic              buf_valid,
    output logic [WORD_W-1:0] o_buf_data,
    output logic              o_word_req,
    output logic [ADDR_W-1:0] o_word_addr,
    input  logic [WORD_W-1:0] i_word_data,
    input  logic              i_word_valid
);

    logic [ROW_W-1:0]  r_row;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_left;
    logic [WORD_W-1:0] r_buf;
    logic              r_buf_valid;
    logic              w_accept;

    assign o_word_req  = (r_left != '0) && !r_buf_valid;
    assign o_word_addr = {r_row, r_idx};
    assign w_accept    = o_word_req && i_word_valid;
    assign buf_valid   = r_buf_valid;
    assign o_buf_data  = r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_idx       <= '0;
            r_left      <= '0;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
        end else if (i_clear) begin
            r_left      <= '0;
            r_buf_valid <= 1'b0;
        end else begin
            // A row load only happens once the previous row is fully fetched,
            // so it never coincides with an accept.
            if (i_row_load) begin
                r_row  <= i_row;
                r_idx  <= '0;
                r_left <= i_count;
            end else if (w_accept) begin
                r_left <= r_left - CNT_W'(1);
                if (r_left != CNT_W'(1)) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end

            if (w_accept) begin
                r_buf       <= i_word_data;
                r_buf_valid <= 1'b1;
            end else if (buf_pop) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_row_sequencer.sv
// rtl/i2s_row_sequencer.sv - row-by-row header+word serializer with gated bit clock; I2S_SEQ_STALL_CNT_EN adds stall_cnt
module i2s_row_sequencer
    import i2s_pkg::*;
#(
    parameter int NUM_ROWS   = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  num_modules_x,
    input  logic [DIM_W-1:0]  num_modules_y,
    output logic              word_req,
    output logic [ADDR_W-1:0] word_addr,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              i2s_data,
    output logic              i2s_clk_en,
    output logic              busy,
    output logic              frame_done
`ifdef I2S_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [15:0]      GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]       BIT_LAST = 4'(WORD_W - 1);

    seq_state_t        r_state;
    logic [DIM_W-1:0]  r_nx;
    logic [DIM_W-1:0]  r_ny;
    logic [ROW_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_words;
    logic [CNT_W-1:0]  r_word_idx;
    logic [WORD_W-1:0] r_shift;
    logic [3:0]        r_bit;
    logic [15:0]       r_gap;
    logic              r_i2s_data;
    logic              r_clk_en;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_buf_valid;
    logic [WORD_W-1:0] w_buf_data;
    logic              w_boundary;
    logic              w_row_end;
    logic              w_start_fire;
    logic              w_next_row;
    logic              w_buf_pop;
    logic              w_stall;
    logic              w_row_load;
    logic [ROW_W-1:0]  w_load_row;
    logic [CNT_W-1:0]  w_load_count;
    logic [HDR_W-1:0]  w_next_hdr;

    // r_bit == 0 means the bit on the line now is the last of its word.
    assign w_boundary   = ((r_state == ST_HEADER) || (r_state == ST_DATA)) && (r_bit == '0);
    assign w_row_end    = w_boundary && (r_state == ST_DATA) && (r_word_idx == r_words - CNT_W'(1));
    assign w_start_fire = (r_state == ST_IDLE) && start && !abort;
    assign w_next_row   = w_row_end && (r_row != LAST_ROW) && !abort;
    assign w_buf_pop    = w_boundary && !w_row_end && w_buf_valid && !abort;
    assign w_stall      = w_boundary && !w_row_end && !w_buf_valid && !abort;
    assign w_row_load   = w_start_fire || w_next_row;
    assign w_load_row   = w_start_fire ? '0 : r_row + ROW_W'(1);
    assign w_load_count = w_start_fire ? word_count(num_modules_x, num_modules_y) : r_words;
    assign w_next_hdr   = make_header(r_nx, r_ny, r_row + ROW_W'(1));

    i2s_word_prefetch u_prefetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (abort),
        .i_row_load   (w_row_load),
        .i_row        (w_load_row),
        .i_count      (w_load_count),
        .buf_pop      (w_buf_pop),
        .buf_valid    (w_buf_valid),
        .o_buf_data   (w_buf_data),
        .o_word_req   (word_req),
        .o_word_addr  (word_addr),
        .i_word_data  (word_data),
        .i_word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_nx         <= '0;
            r_ny         <= '0;
            r_row        <= '0;
            r_words      <= '0;
            r_word_idx   <= '0;
            r_shift      <= '0;
            r_bit        <= '0;
            r_gap        <= '0;
            r_i2s_data   <= 1'b0;
            r_clk_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (abort) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_clk_en   <= 1'b0;
                r_word_idx <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_nx       <= num_modules_x;
                            r_ny       <= num_modules_y;
                            r_words    <= word_count(num_modules_x, num_modules_y);
                            r_row      <= '0;
                            r_word_idx <= '0;
                            r_shift    <= make_header(num_modules_x, num_modules_y, '0);
                            r_i2s_data <= num_modules_x[DIM_W-1];
                            r_bit      <= BIT_LAST;
                            r_clk_en   <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= ST_HEADER;
                        end
                    end
                    ST_HEADER, ST_DATA: begin
                        if (r_bit != '0) begin
                            r_shift    <= {r_shift[WORD_W-2:0], 1'b0};
                            r_i2s_data <= r_shift[WORD_W-2];
                            r_bit      <= r_bit - 4'd1;
                            r_clk_en   <= 1'b1;
                        end else if (w_row_end) begin
                            r_word_idx <= '0;
                            if (r_row == LAST_ROW) begin
                                r_state      <= ST_IDLE;
                                r_busy       <= 1'b0;
                                r_clk_en     <= 1'b0;
                                r_frame_done <= 1'b1;
                            end else if (GAP_CYCLES == 0) begin
                                r_row      <= r_row + ROW_W'(1);
                                r_shift    <= w_next_hdr;
                                r_i2s_data <= w_next_hdr[HDR_W-1];
                                r_bit      <= BIT_LAST;
                                r_clk_en   <= 1'b1;
                                r_state    <= ST_HEADER;
                            end else begin
                                r_gap    <= '0;
                                r_clk_en <= 1'b0;
                                r_state  <= ST_GAP;
                            end
                        end else if (w_buf_valid) begin
                            r_shift    <= w_buf_data;
                            r_i2s_data <= w_buf_data[WORD_W-1];
                            r_bit      <= BIT_LAST;
                            r_clk_en   <= 1'b1;
                            if (r_state == ST_DATA) begin
                                r_word_idx <= r_word_idx + CNT_W'(1);
                            end
                            r_state    <= ST_DATA;
                        end else begin
                            // Withhold the clock edge; i2s_data keeps the last bit.
                            r_clk_en <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        if (r_gap == GAP_LAST) begin
                            r_row      <= r_row + ROW_W'(1);
                            r_shift    <= w_next_hdr;
                            r_i2s_data <= w_next_hdr[HDR_W-1];
                            r_bit      <= BIT_LAST;
                            r_clk_en   <= 1'b1;
                            r_state    <= ST_HEADER;
                        end else begin
                            r_gap <= r_gap + 16'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef I2S_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_fire) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic w_unused_stall;
    assign w_unused_stall = w_stall;
`endif

    assign i2s_data   = r_i2s_data;
    assign i2s_clk_en = r_clk_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_i2s_row_sequencer.sv
// tb/tb_i2s_row_sequencer.sv - directed self-checking bench for i2s_row_sequencer
module tb_i2s_row_sequencer;

    localparam int NUM_ROWS   = 8;
    localparam int GAP_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  nmx = 4'd0;
    logic [3:0]  nmy = 4'd0;
    logic        word_req;
    logic [13:0] word_addr;
    logic [15:0] word_data;
    logic        word_valid;
    logic        i2s_data;
    logic        i2s_clk_en;
    logic        busy;
    logic        frame_done;
`ifdef I2S_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int mem_lat = 0;
    int lat_cnt = 0;

    bit q[$];
    bit mon_on = 1'b0;
    bit last_bit = 1'b0;
    int run = 0;
    int n24 = 0;
    int n22 = 0;
    int ngap = 0;
    int nother = 0;
    int hold_err = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [13:0] a);
        return {a[7:0], 2'b01, a[13:8]};
    endfunction

    assign word_data  = mem_word(word_addr);
    assign word_valid = word_req && (lat_cnt >= mem_lat);

    // Memory answers once the request has been held for mem_lat cycles.
    always @(posedge clk) lat_cnt <= (word_req && !word_valid) ? lat_cnt + 1 : 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (i2s_clk_en) begin
                if (run > 0) begin
                    if (run == 24) n24++;
                    else if (run == 22) n22++;
                    else if (run == GAP_CYCLES) ngap++;
                    else nother++;
                end
                run = 0;
                q.push_back(i2s_data);
                last_bit = i2s_data;
            end else if (busy) begin
                run++;
                if (run > GAP_CYCLES && i2s_data !== last_bit) hold_err++;
            end
        end
    end

    i2s_row_sequencer #(.NUM_ROWS(NUM_ROWS), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_modules_x (nmx),
        .num_modules_y (nmy),
        .word_req      (word_req),
        .word_addr     (word_addr),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .i2s_data      (i2s_data),
        .i2s_clk_en    (i2s_clk_en),
        .busy          (busy),
        .frame_done    (frame_done)
`ifdef I2S_SEQ_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    function automatic int stream_errors(input logic [3:0] nx, input logic [3:0] ny);
        logic [15:0] w;
        int words;
        int k;
        int errs;
        words = (int'(nx) + 1) * (int'(ny) + 1);
        k = 0;
        errs = 0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            w = {nx, ny, 2'b00, 6'(r)};
            for (int b = 15; b >= 0; b--) begin
                if (k >= q.size() || q[k] !== w[b]) errs++;
                k++;
            end
            for (int i = 0; i < words; i++) begin
                w = mem_word({6'(r), 8'(i)});
                for (int b = 15; b >= 0; b--) begin
                    if (k >= q.size() || q[k] !== w[b]) errs++;
                    k++;
                end
            end
        end
        if (k != q.size()) errs++;
        return errs;
    endfunction

    function automatic logic [15:0] q_word(input int off);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            if (off + i < q.size()) w[15-i] = q[off+i];
        end
        return w;
    endfunction

    task automatic clear_mon();
        q.delete();
        run = 0;
        n24 = 0;
        n22 = 0;
        ngap = 0;
        nother = 0;
        hold_err = 0;
    endtask

    task automatic start_frame(input logic [3:0] nx, input logic [3:0] ny);
        @(negedge clk);
        nmx = nx;
        nmy = ny;
        clear_mon();
        mon_on = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen, input int stray_at);
        seen = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            start = (c == stray_at);
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({word_req, word_addr, i2s_data, i2s_clk_en, busy, frame_done} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {word_req, word_addr, i2s_data, i2s_clk_en, busy, frame_done});
        end
`ifdef I2S_SEQ_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0h expected 0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_latency();
        bit seen;
        mem_lat = 0;
        start_frame(4'd3, 4'd3);
        n_checks++;
        if ({busy, i2s_clk_en, i2s_data} !== 3'b110) begin
            n_fail++;
            $display("FAIL first_bit: got %b expected 110", {busy, i2s_clk_en, i2s_data});
        end
        wait_done(seen, -1);
        n_checks++;
        if (!seen || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zl_frame_done: got seen=%0d busy=%b expected seen=1 busy=0", seen, busy);
        end
        n_checks++;
        if (q_word(0) !== 16'h3300) begin
            n_fail++;
            $display("FAIL row0_header: got %h expected 3300", q_word(0));
        end
        n_checks++;
        if (q_word(272) !== 16'h3301) begin
            n_fail++;
            $display("FAIL row1_header: got %h expected 3301", q_word(272));
        end
        n_checks++;
        if (stream_errors(4'd3, 4'd3) != 0) begin
            n_fail++;
            $display("FAIL zl_stream: got %0d bit errors expected 0", stream_errors(4'd3, 4'd3));
        end
        n_checks++;
        if (ngap != NUM_ROWS - 1 || (nother + n22 + n24) != 0) begin
            n_fail++;
            $display("FAIL zl_clk_en_low: got gaps=%0d other=%0d expected gaps=%0d other=0",
                     ngap, nother + n22 + n24, NUM_ROWS - 1);
        end
        n_checks++;
        if (word_addr !== {6'd7, 8'd15}) begin
            n_fail++;
            $display("FAIL zl_last_addr: got %h expected %h", word_addr, {6'd7, 8'd15});
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_done_pulse: got %b expected 0", frame_done);
        end
        mon_on = 1'b0;
    endtask

    task automatic test_latency();
        bit seen;
        // 38 cycles of request-to-valid gives a 40-cycle word period: 24-cycle stalls.
        mem_lat = 38;
        start_frame(4'd3, 4'd3);
        wait_done(seen, -1);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL lat_frame_done: got none expected pulse");
        end
        n_checks++;
        if (stream_errors(4'd3, 4'd3) != 0) begin
            n_fail++;
            $display("FAIL lat_stream: got %0d bit errors expected 0", stream_errors(4'd3, 4'd3));
        end
        n_checks++;
        if (n24 != 121 || n22 != 7 || ngap != 7 || nother != 0) begin
            n_fail++;
            $display("FAIL lat_stall_runs: got n24=%0d n22=%0d ngap=%0d other=%0d expected 121 7 7 0",
                     n24, n22, ngap, nother);
        end
        n_checks++;
        if (hold_err != 0) begin
            n_fail++;
            $display("FAIL lat_data_hold: got %0d changes expected 0", hold_err);
        end
`ifdef I2S_SEQ_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd3058) begin
            n_fail++;
            $display("FAIL lat_stall_cnt: got %0d expected 3058", stall_cnt);
        end
`endif
        mon_on = 1'b0;
        mem_lat = 0;
    endtask

    task automatic test_sizes();
        bit seen;
        mem_lat = 0;
        start_frame(4'd0, 4'd0);
        wait_done(seen, -1);
        n_checks++;
        if (!seen || stream_errors(4'd0, 4'd0) != 0) begin
            n_fail++;
            $display("FAIL w1_stream: got seen=%0d errors=%0d expected seen=1 errors=0",
                     seen, stream_errors(4'd0, 4'd0));
        end
        n_checks++;
        if (word_addr !== {6'd7, 8'd0}) begin
            n_fail++;
            $display("FAIL w1_last_addr: got %h expected %h", word_addr, {6'd7, 8'd0});
        end
        start_frame(4'd15, 4'd15);
        wait_done(seen, -1);
        n_checks++;
        if (!seen || stream_errors(4'd15, 4'd15) != 0) begin
            n_fail++;
            $display("FAIL w256_stream: got seen=%0d errors=%0d expected seen=1 errors=0",
                     seen, stream_errors(4'd15, 4'd15));
        end
        n_checks++;
        if (word_addr !== {6'd7, 8'd255} || q_word(0) !== 16'hFF00) begin
            n_fail++;
            $display("FAIL w256_addr_hdr: got addr=%h hdr=%h expected addr=%h hdr=ff00",
                     word_addr, q_word(0), {6'd7, 8'd255});
        end
        mon_on = 1'b0;
    endtask

    task automatic test_abort();
        bit seen;
        bit found;
        int fd;
        mem_lat = 38;
        start_frame(4'd1, 4'd1);
        found = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (word_req && word_addr == {6'd2, 8'd2}) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_row2: got found=%0d busy=%b expected 1 1", found, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({busy, i2s_clk_en, word_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_idle: got %b expected 000", {busy, i2s_clk_en, word_req});
        end
        fd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (frame_done) fd++;
        end
        n_checks++;
        if (fd != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", fd);
        end
        mem_lat = 0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if ({busy, i2s_clk_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_over_start: got %b expected 00", {busy, i2s_clk_en});
        end
        start_frame(4'd1, 4'd1);
        wait_done(seen, -1);
        n_checks++;
        if (!seen || stream_errors(4'd1, 4'd1) != 0) begin
            n_fail++;
            $display("FAIL abort_restart: got seen=%0d errors=%0d expected seen=1 errors=0",
                     seen, stream_errors(4'd1, 4'd1));
        end
        mon_on = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit seen;
        mem_lat = 0;
        start_frame(4'd8, 4'd0);
        wait_done(seen, 100);
        n_checks++;
        if (!seen || stream_errors(4'd8, 4'd0) != 0) begin
            n_fail++;
            $display("FAIL start_while_busy: got seen=%0d errors=%0d expected seen=1 errors=0",
                     seen, stream_errors(4'd8, 4'd0));
        end
        start = 1'b1;
        clear_mon();
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, i2s_clk_en, i2s_data} !== 3'b111) begin
            n_fail++;
            $display("FAIL b2b_first_bit: got %b expected 111", {busy, i2s_clk_en, i2s_data});
        end
        wait_done(seen, -1);
        n_checks++;
        if (!seen || stream_errors(4'd8, 4'd0) != 0) begin
            n_fail++;
            $display("FAIL b2b_stream: got seen=%0d errors=%0d expected seen=1 errors=0",
                     seen, stream_errors(4'd8, 4'd0));
        end
        mon_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_lat = 0;
        start_frame(4'd3, 4'd3);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({word_req, word_addr, i2s_data, i2s_clk_en, busy, frame_done} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid_word: got %0h expected 0",
                     {word_req, word_addr, i2s_data, i2s_clk_en, busy, frame_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_latency();
        test_sizes();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
